// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: receive-stage state encoding, default field
// widths, command codes and an address range helper.
package bus_pkg;

  localparam int ADDR_SIZE  = 12;
  localparam int WORD_SIZE  = 8;
  localparam int BURST_SIZE = 15;

  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_B_READ  = 3'd3;
  localparam logic [2:0] S_B_WRITE = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_RX,
    CMD,
    BURST_RX,
    DATA_RX,
    WR_STALL,
    RD_REQ,
    RD_WAIT
  } slave_in_state_t;

  // True when words [start, start+len) all lie inside a memory of depth words.
  function automatic logic range_ok(input int unsigned start, input int unsigned len,
                                    input int unsigned depth);
    return (start < depth) && (start + len <= depth);
  endfunction

endpackage

// File: rtl/serial_shift_rx.sv
// LSB-first serial-to-parallel shifter with bit counter, last-bit flag and clear.
// value_next shows the word including the bit being shifted in this cycle.
module serial_shift_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] value_next,
  output logic             last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0] cnt;

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    value_next      = value;
    value_next[cnt] = bit_in;
  end

  // Clear wins over shift so a bit arriving on an abort is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      cnt   <= '0;
    end else if (clear) begin
      value <= '0;
      cnt   <= '0;
    end else if (shift_en) begin
      value <= value_next;
      cnt   <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/slave_in_port.sv
// Slave receive stage: deserialises address/burst/write-data streams and issues
// core writes or read requests. Define SLAVE_IN_ADDR_CHECK_EN to range-check against MEM_DEPTH.
module slave_in_port
  import bus_pkg::*;
#(
  parameter int ADDR_SIZE  = bus_pkg::ADDR_SIZE,
  parameter int WORD_SIZE  = bus_pkg::WORD_SIZE,
  parameter int BURST_SIZE = bus_pkg::BURST_SIZE,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel,
  input  logic                  addr_bus,
  input  logic                  addr_done,
  input  logic                  read_en,
  input  logic                  m_b_tx_valid,
  input  logic                  burst_size_bus,
  input  logic                  burst_done,
  input  logic                  m_valid,
  input  logic                  w_data_bus,
  input  logic                  tx_done,
  input  logic                  core_wr_ready,
  input  logic                  core_rd_done,
  output logic                  s_ready,
  output logic [ADDR_SIZE-1:0]  core_addr,
  output logic [WORD_SIZE-1:0]  core_wdata,
  output logic                  core_we,
  output logic                  core_rd_req,
  output logic [BURST_SIZE-1:0] core_burst_len,
  output logic                  proto_err
);

  // Handshake: a bus bit is consumed on a rising edge where s_ready (registered,
  // equal to "next state accepts bits") is high and the stream's qualifier is
  // high (sel for address/burst bits, m_valid for write-data bits).

  slave_in_state_t state, state_nxt;

  logic                  addr_shift, burst_shift, data_shift, clear_all;
  logic                  addr_last, burst_last, data_last;
  logic [ADDR_SIZE-1:0]  addr_val, unused_addr_next;
  logic [BURST_SIZE-1:0] burst_val, unused_burst_next;
  logic [WORD_SIZE-1:0]  data_next, unused_word;

  logic                  rd_flag, bt_flag, done_pend;
  logic [ADDR_SIZE-1:0]  word_idx, wr_addr;
  logic [BURST_SIZE-1:0] burst_len_eff;
  logic                  wr_ok, rd_ok;

  logic       we_nxt, rd_req_nxt, err_nxt, commit_ld, rd_ld, word_inc, word_clr;
  logic       flags_ld, pend_ld;
  logic [2:0] cmd;

  serial_shift_rx #(.WIDTH(ADDR_SIZE)) u_addr_rx (
    .clk(clk), .rst_n(rst_n), .clear(clear_all), .shift_en(addr_shift),
    .bit_in(addr_bus), .value(addr_val), .value_next(unused_addr_next), .last(addr_last)
  );

  serial_shift_rx #(.WIDTH(BURST_SIZE)) u_burst_rx (
    .clk(clk), .rst_n(rst_n), .clear(clear_all), .shift_en(burst_shift),
    .bit_in(burst_size_bus), .value(burst_val), .value_next(unused_burst_next), .last(burst_last)
  );

  serial_shift_rx #(.WIDTH(WORD_SIZE)) u_data_rx (
    .clk(clk), .rst_n(rst_n), .clear(clear_all), .shift_en(data_shift),
    .bit_in(w_data_bus), .value(unused_word), .value_next(data_next), .last(data_last)
  );

  assign wr_addr       = addr_val + word_idx;
  // A single read leaves the burst field cleared, so zero maps to one word too.
  assign burst_len_eff = (burst_val == '0) ? BURST_SIZE'(1) : burst_val;

`ifdef SLAVE_IN_ADDR_CHECK_EN
  assign wr_ok = range_ok(32'(wr_addr), 32'd1, MEM_DEPTH);
  assign rd_ok = range_ok(32'(addr_val), 32'(burst_len_eff), MEM_DEPTH);
`else
  logic unused_depth;
  assign unused_depth = ^MEM_DEPTH;
  assign wr_ok = 1'b1;
  assign rd_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    addr_shift  = 1'b0;
    burst_shift = 1'b0;
    data_shift  = 1'b0;
    we_nxt      = 1'b0;
    rd_req_nxt  = 1'b0;
    err_nxt     = 1'b0;
    commit_ld   = 1'b0;
    rd_ld       = 1'b0;
    word_inc    = 1'b0;
    flags_ld    = 1'b0;
    pend_ld     = 1'b0;
    cmd         = S_WRITE;
    unique case (state)
      IDLE, ADDR_RX: begin
        if (!sel) begin
          if (state == ADDR_RX) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end
        end else if (s_ready) begin
          addr_shift = 1'b1;
          state_nxt  = ADDR_RX;
          if (addr_last) begin
            flags_ld  = 1'b1;
            err_nxt   = !addr_done;
            state_nxt = CMD;
          end
        end
      end
      CMD: begin
        if (rd_flag | read_en) cmd = (bt_flag | m_b_tx_valid) ? S_B_READ : S_READ;
        else                   cmd = (bt_flag | m_b_tx_valid) ? S_B_WRITE : S_WRITE;
        if (!sel) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else begin
          case (cmd)
            S_B_READ: state_nxt = BURST_RX;
            S_READ:   state_nxt = RD_REQ;
            default:  state_nxt = DATA_RX;
          endcase
        end
      end
      BURST_RX: begin
        if (!sel) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else begin
          burst_shift = 1'b1;
          if (burst_last) begin
            err_nxt   = !burst_done;
            state_nxt = RD_REQ;
          end
        end
      end
      DATA_RX: begin
        if (!sel) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else if (m_valid && s_ready) begin
          data_shift = 1'b1;
          if (data_last) begin
            if (!wr_ok) begin
              err_nxt   = 1'b1;
              word_inc  = 1'b1;
              state_nxt = tx_done ? IDLE : DATA_RX;
            end else begin
              commit_ld = 1'b1;
              if (core_wr_ready) begin
                we_nxt    = 1'b1;
                word_inc  = 1'b1;
                state_nxt = tx_done ? IDLE : DATA_RX;
              end else begin
                pend_ld   = 1'b1;
                state_nxt = WR_STALL;
              end
            end
          end else if (tx_done) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WR_STALL: begin
        if (!sel) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else if (core_wr_ready) begin
          we_nxt    = 1'b1;
          word_inc  = 1'b1;
          state_nxt = done_pend ? IDLE : DATA_RX;
        end
      end
      RD_REQ: begin
        if (!sel) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else if (rd_ok) begin
          rd_req_nxt = 1'b1;
          rd_ld      = 1'b1;
          state_nxt  = RD_WAIT;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD_WAIT: begin
        if (core_rd_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clear_all = (state_nxt == IDLE);
  assign word_clr  = clear_all || (state == CMD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready        <= 1'b0;
      core_addr      <= '0;
      core_wdata     <= '0;
      core_we        <= 1'b0;
      core_rd_req    <= 1'b0;
      core_burst_len <= '0;
      proto_err      <= 1'b0;
      rd_flag        <= 1'b0;
      bt_flag        <= 1'b0;
      done_pend      <= 1'b0;
      word_idx       <= '0;
    end else begin
      s_ready     <= (state_nxt inside {IDLE, ADDR_RX, BURST_RX, DATA_RX});
      core_we     <= we_nxt;
      core_rd_req <= rd_req_nxt;
      proto_err   <= err_nxt;
      if (commit_ld) begin
        core_addr  <= wr_addr;
        core_wdata <= data_next;
      end
      if (rd_ld) begin
        core_addr      <= addr_val;
        core_burst_len <= burst_len_eff;
      end
      if (flags_ld) begin
        rd_flag <= read_en;
        bt_flag <= m_b_tx_valid;
      end
      if (pend_ld) done_pend <= tx_done;
      if (word_clr)      word_idx <= '0;
      else if (word_inc) word_idx <= word_idx + ADDR_SIZE'(1);
    end
  end

endmodule

// File: tb/tb_slave_in_port.sv
// Directed bench for slave_in_port: table of write/read transactions plus
// hand sequences for stall, abort, early tx_done, missing addr_done and reset.
module tb_slave_in_port;

`ifdef SLAVE_IN_ADDR_CHECK_EN
  localparam int TB_DEPTH = 256;
`else
  localparam int TB_DEPTH = 4096;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel, addr_bus, addr_done, read_en, m_b_tx_valid;
  logic        burst_size_bus, burst_done, m_valid, w_data_bus, tx_done;
  logic        core_wr_ready, core_rd_done;
  logic        s_ready, core_we, core_rd_req, proto_err;
  logic [11:0] core_addr;
  logic [7:0]  core_wdata;
  logic [14:0] core_burst_len;

  slave_in_port #(.MEM_DEPTH(TB_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .addr_bus(addr_bus), .addr_done(addr_done),
    .read_en(read_en), .m_b_tx_valid(m_b_tx_valid), .burst_size_bus(burst_size_bus),
    .burst_done(burst_done), .m_valid(m_valid), .w_data_bus(w_data_bus), .tx_done(tx_done),
    .core_wr_ready(core_wr_ready), .core_rd_done(core_rd_done), .s_ready(s_ready),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we),
    .core_rd_req(core_rd_req), .core_burst_len(core_burst_len), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [19:0] exp_q[$];
  logic [19:0] got_q[$];
  int          rd_cnt = 0;
  int          err_cnt = 0;
  logic [11:0] rd_addr;
  logic [14:0] rd_len;
  int          ready_hold = 0;
  int          wait_total = 0;

  typedef struct {
    int               kind;      // 0 write, 1 single read, 2 burst read
    logic [11:0]      addr;
    int               nw;
    logic [2:0][7:0]  data;
    logic [14:0]      blen;
    logic [2:0][11:0] exp_a;
    logic [14:0]      exp_len;
  } vec_t;

  vec_t vecs[7];

  always @(negedge clk) begin
    if (rst_n) begin
      if (core_we) got_q.push_back({core_addr, core_wdata});
      if (core_rd_req) begin
        rd_cnt++;
        rd_addr = core_addr;
        rd_len  = core_burst_len;
      end
      if (proto_err) err_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_writes(input string name);
    logic [19:0] e, g;
    check({name, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 20'hxxxxx;
      check(name, g, e);
    end
    got_q.delete();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 40) begin
      m_valid = 1'b0;
      wait_total++;
      n++;
      if (ready_hold > 0) ready_hold--;
      else core_wr_ready = 1'b1;
      @(negedge clk);
    end
    if (!s_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: s_ready 0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic send_addr(input logic [11:0] a, input bit rd, input bit bt, input bit done_ok);
    @(negedge clk);
    wait_ready();
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      sel          = 1'b1;
      addr_bus     = a[i];
      addr_done    = (i == 11) && done_ok;
      read_en      = rd && (i == 11);
      m_b_tx_valid = bt && (i == 11);
    end
    @(negedge clk);
    addr_bus = 1'b0; addr_done = 1'b0; read_en = 1'b0; m_b_tx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input int tx_bit, input int stall);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      wait_ready();
      m_valid    = 1'b1;
      w_data_bus = d[b];
      tx_done    = (b == tx_bit);
      if (b == 7 && stall > 0) begin
        core_wr_ready = 1'b0;
        ready_hold    = stall - 1;
      end
      if (b == tx_bit) break;
    end
  endtask

  task automatic finish_tx();
    @(negedge clk);
    m_valid = 1'b0; tx_done = 1'b0; sel = 1'b0; w_data_bus = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_burst(input logic [14:0] blen);
    for (int b = 0; b < 15; b++) begin
      @(negedge clk);
      if (b == 0) wait_ready();
      burst_size_bus = blen[b];
      burst_done     = (b == 14);
    end
    @(negedge clk);
    burst_size_bus = 1'b0; burst_done = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [11:0] a, input bit bt,
                         input logic [14:0] blen, input logic [14:0] exp_len);
    int rd0 = rd_cnt;
    int er0 = err_cnt;
    send_addr(a, 1'b1, bt, 1'b1);
    if (bt) send_burst(blen);
    repeat (4) @(negedge clk);
    check({name, "_hold_s_ready"}, s_ready, 1'b0);
    core_rd_done = 1'b1;
    @(negedge clk);
    core_rd_done = 1'b0; sel = 1'b0;
    check({name, "_release_s_ready"}, s_ready, 1'b1);
    repeat (2) @(negedge clk);
    check({name, "_req_count"}, rd_cnt - rd0, 1);
    check({name, "_addr"}, rd_addr, a);
    check({name, "_len"}, rd_len, exp_len);
    check({name, "_err"}, err_cnt - er0, 0);
    check_writes({name, "_no_write"});
  endtask

  initial begin
    int er0, rd0;
    rst_n = 1'b0;
    sel = 0; addr_bus = 0; addr_done = 0; read_en = 0; m_b_tx_valid = 0;
    burst_size_bus = 0; burst_done = 0; m_valid = 0; w_data_bus = 0; tx_done = 0;
    core_wr_ready = 1'b1; core_rd_done = 1'b0;

    vecs[0] = '{0, 12'hA5C, 1, {8'h00, 8'h00, 8'h3C}, 15'd0, {12'h000, 12'h000, 12'hA5C}, 15'd0};
    vecs[1] = '{0, 12'h100, 3, {8'h33, 8'h22, 8'h11}, 15'd0, {12'h102, 12'h101, 12'h100}, 15'd0};
    vecs[2] = '{0, 12'hFFE, 2, {8'h00, 8'h00, 8'hFF}, 15'd0, {12'h000, 12'hFFF, 12'hFFE}, 15'd0};
    vecs[3] = '{1, 12'h7FF, 0, 24'h0, 15'd0, 36'h0, 15'd1};
    vecs[4] = '{2, 12'h010, 0, 24'h0, 15'd5, 36'h0, 15'd5};
    vecs[5] = '{2, 12'h123, 0, 24'h0, 15'd0, 36'h0, 15'd1};
    vecs[6] = '{2, 12'hABC, 0, 24'h0, 15'h7FFF, 36'h0, 15'h7FFF};

    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_core_we", core_we, 1'b0);
    check("rst_core_rd_req", core_rd_req, 1'b0);
    check("rst_proto_err", proto_err, 1'b0);
    check("rst_core_addr", core_addr, 12'h0);
    check("rst_core_wdata", core_wdata, 8'h0);
    check("rst_core_burst_len", core_burst_len, 15'h0);
    rst_n = 1'b1;
    check("release_s_ready_low", s_ready, 1'b0);
    @(negedge clk);
    check("first_clock_s_ready", s_ready, 1'b1);

`ifdef SLAVE_IN_ADDR_CHECK_EN
    do_read("in_range_read", 12'h010, 1'b1, 15'd5, 15'd5);
    er0 = err_cnt; rd0 = rd_cnt;
    send_addr(12'h0FE, 1'b1, 1'b1, 1'b1);
    send_burst(15'd4);
    repeat (4) @(negedge clk);
    sel = 1'b0;
    repeat (2) @(negedge clk);
    check("oor_read_no_req", rd_cnt - rd0, 0);
    check("oor_read_err", err_cnt - er0, 1);
    check("oor_read_back_idle", s_ready, 1'b1);
`else
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].kind == 0) begin
        er0 = err_cnt;
        send_addr(vecs[v].addr, 1'b0, 1'b0, 1'b1);
        for (int w = 0; w < vecs[v].nw; w++) begin
          send_word(vecs[v].data[w], (w == vecs[v].nw - 1) ? 7 : -1, 0);
          exp_q.push_back({vecs[v].exp_a[w], vecs[v].data[w]});
        end
        finish_tx();
        check_writes($sformatf("vec%0d_write", v));
        check($sformatf("vec%0d_err", v), err_cnt - er0, 0);
      end else begin
        do_read($sformatf("vec%0d_read", v), vecs[v].addr, vecs[v].kind == 2,
                vecs[v].blen, vecs[v].exp_len);
      end
    end

    // Burst write across the address wrap with a 4-cycle core stall on word 1.
    er0 = err_cnt;
    send_addr(12'hFFF, 1'b0, 1'b0, 1'b1);
    wait_total = 0;
    send_word(8'hA1, -1, 0);
    send_word(8'hB2, -1, 4);
    send_word(8'hC3, 7, 0);
    finish_tx();
    check("stall_s_ready_low_cycles", wait_total, 4);
    exp_q.push_back({12'hFFF, 8'hA1});
    exp_q.push_back({12'h000, 8'hB2});
    exp_q.push_back({12'h001, 8'hC3});
    check_writes("stall_write");
    check("stall_err", err_cnt - er0, 0);

    // sel drops after address bit 6.
    er0 = err_cnt; rd0 = rd_cnt;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sel = 1'b1;
      addr_bus = i[0];
    end
    @(negedge clk);
    sel = 1'b0; addr_bus = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_err", err_cnt - er0, 1);
    check("abort_no_rd", rd_cnt - rd0, 0);
    check_writes("abort_no_write");
    send_addr(12'h0F0, 1'b0, 1'b0, 1'b1);
    send_word(8'h5A, 7, 0);
    finish_tx();
    exp_q.push_back({12'h0F0, 8'h5A});
    check_writes("after_abort_write");
    check("after_abort_err", err_cnt - er0, 1);

    // tx_done on bit 3 of word 2.
    er0 = err_cnt;
    send_addr(12'h200, 1'b0, 1'b0, 1'b1);
    send_word(8'h81, -1, 0);
    send_word(8'h42, -1, 0);
    send_word(8'h9F, 3, 0);
    finish_tx();
    exp_q.push_back({12'h200, 8'h81});
    exp_q.push_back({12'h201, 8'h42});
    check_writes("early_done_write");
    check("early_done_err", err_cnt - er0, 1);

    // addr_done missing on the last address bit: error, but the write proceeds.
    er0 = err_cnt;
    send_addr(12'h333, 1'b0, 1'b0, 1'b0);
    send_word(8'h77, 7, 0);
    finish_tx();
    exp_q.push_back({12'h333, 8'h77});
    check_writes("no_addr_done_write");
    check("no_addr_done_err", err_cnt - er0, 1);

    // Reset in the middle of a data word.
    send_addr(12'h444, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      m_valid = 1'b1; w_data_bus = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0; m_valid = 1'b0; sel = 1'b0; w_data_bus = 1'b0;
    #1;
    check("midreset_s_ready", s_ready, 1'b0);
    check("midreset_core_addr", core_addr, 12'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_release_s_ready", s_ready, 1'b1);
    check_writes("midreset_no_write");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slave_in_port.md
Name: slave_in_port

Overview:
- Slave-side receive stage; sits directly downstream of the master out-port on the serial bus.
- Deserialises the address, write-data and burst-length bit streams for one slave.
- Issues parallel write commits or read requests to the slave memory core.
- Drives s_ready back to the bus for bit-level flow control.

Parameters:
- ADDR_SIZE, 12, slave-local address width; address serialised LSB first.
- WORD_SIZE, 8, data word width; serialised LSB first.
- BURST_SIZE, 15, width of the serial burst-length field.
- MEM_DEPTH, 4096, number of valid word locations; used only by the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- sel  in  1  this slave's slave_select bit
- addr_bus  in  1  serial address bit
- addr_done  in  1  marks the last address bit
- read_en  in  1  read transaction; valid with the last address bit
- m_b_tx_valid  in  1  burst-length bits follow the address
- burst_size_bus  in  1  serial burst-length bit
- burst_done  in  1  marks the last burst-length bit
- m_valid  in  1  w_data_bus bit valid
- w_data_bus  in  1  serial write-data bit
- tx_done  in  1  last write bit of the transaction
- core_wr_ready  in  1  core can accept core_we
- core_rd_done  in  1  read data fully returned by the slave out-port
- s_ready  out  1  slave accepts a bit this cycle
- core_addr  out  ADDR_SIZE  word address to core
- core_wdata  out  WORD_SIZE  assembled write word
- core_we  out  1  one-cycle write strobe
- core_rd_req  out  1  one-cycle read request
- core_burst_len  out  BURST_SIZE  read length in words (1 for single read)
- proto_err  out  1  one-cycle protocol-error pulse

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. s_ready rises in the first clock after reset release.
- States: IDLE, ADDR_RX, CMD, BURST_RX, DATA_RX, WR_STALL, RD_REQ, RD_WAIT.
- s_ready = 1 in IDLE, ADDR_RX, BURST_RX and DATA_RX; 0 otherwise. It is registered and reflects the next state.
- IDLE: sel=1 → ADDR_RX. Sampling of addr_bus begins the same cycle (the master drives bit 0 in its first ADDR_TX cycle).
- ADDR_RX: each cycle sel&s_ready, latch addr_bus into addr[bit_cnt] and increment bit_cnt.
  - At bit_cnt==ADDR_SIZE-1 → CMD.
  - addr_done not high on that bit → proto_err pulse, but the transaction continues.
- CMD (1 cycle):
  - read_en & m_b_tx_valid → BURST_RX.
  - read_en alone → RD_REQ with core_burst_len=1.
  - Otherwise → DATA_RX with word_idx=0.
- BURST_RX: shift BURST_SIZE bits LSB first, then → RD_REQ.
  - burst_done absent on the last bit → proto_err.
  - A length of 0 is treated as 1.
- RD_REQ: core_rd_req=1 for exactly one cycle; core_addr=addr; → RD_WAIT.
- RD_WAIT: hold until core_rd_done → IDLE.
- DATA_RX: each m_valid&s_ready cycle, latch w_data_bus into word[bit_cnt]. On bit WORD_SIZE-1:
  - core_wdata = word; core_addr = addr+word_idx, modulo 2^ADDR_SIZE (wraps).
  - core_wr_ready=1: core_we pulses the next cycle. Otherwise → WR_STALL (s_ready=0) until ready, then pulse core_we.
  - word_idx increments after each commit.
- tx_done handling:
  - tx_done with the last bit of a word: commit that word, then → IDLE.
  - tx_done mid-word: discard the partial word, proto_err, → IDLE.
- Abort: sel falling in any state other than IDLE/RD_WAIT → IDLE next cycle, proto_err, no core strobe.
- Simultaneous core_wr_ready falling with the last bit: stall; the word is never dropped.
- Reset mid-operation: immediate return to reset values; any pending strobe is lost.

Optional Feature:
- Macro SLAVE_IN_ADDR_CHECK_EN.
- Defined: every commit/request address is compared with MEM_DEPTH.
  - Out-of-range write word: no core_we, proto_err pulse, reception continues.
  - Out-of-range read start, or start+len > MEM_DEPTH: no core_rd_req, proto_err, → IDLE.
- Undefined: no range check; addresses wrap modulo 2^ADDR_SIZE.

Decomposition:
- Shared package bus_pkg: slave_in_state_t enum, default widths ADDR_SIZE/WORD_SIZE/BURST_SIZE, command codes S_READ=1, S_WRITE=2, S_B_READ=3, S_B_WRITE=4.
- One sub-module, serial_shift_rx: parameterised WIDTH LSB-first shifter with bit counter, last-bit flag and clear. Instantiated for the address, burst and data fields.

Test Plan:
- Single write, addr=0xA5C, data=0x3C, tx_done on bit 7 → one core_we, core_addr=0xA5C, core_wdata=0x3C; back to IDLE.
- Burst write of 3 words at 0xFFF with core_wr_ready low for 4 cycles on word 1 → s_ready low 4 cycles; writes land at 0xFFF, 0x000, 0x001.
- Burst read, addr=0x010, burst length 5 → single core_rd_req, core_burst_len=5; hold until core_rd_done.
- sel drops after address bit 6 → proto_err pulse, no core strobes; next transaction decodes correctly.
- tx_done on bit 3 of word 2 → words 0–1 committed, partial word dropped, proto_err pulse.
- With SLAVE_IN_ADDR_CHECK_EN and MEM_DEPTH=256: read at 0x0FE, length 4 → no core_rd_req, proto_err pulse.
